// File: rtl/dda_column_buffer.sv
// Ping-pong column store between the DDA ray-cast stage and the renderer.
// Columns may be written in any order. The banks swap at a frame start, but only once the write bank is full.
module dda_column_buffer #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic [8:0]  hcount_ray_in,
    input  logic [15:0] lineHeight_in,
    input  logic        wallType_in,
    input  logic [3:0]  mapData_in,
    input  logic [15:0] wallX_in,
    input  logic        valid_in,
    input  logic        frame_start_in,
    input  logic        rd_req_in,
    input  logic [8:0]  rd_hcount_in,
    output logic [7:0]  drawStart_out,
    output logic [7:0]  drawEnd_out,
    output logic        wallType_out,
    output logic [3:0]  mapData_out,
    output logic [15:0] wallX_out,
    output logic        rd_valid_out,
    output logic        frame_request_out,
    output logic        write_done_out,
    output logic        err_out
);

    localparam int CNT_W  = $clog2(SCREEN_WIDTH + 1);
    localparam int DEPTH  = 2 * SCREEN_WIDTH;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int ENTRY_W = 37;

    localparam logic [8:0]        COL_LIMIT  = 9'(SCREEN_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(SCREEN_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(SCREEN_WIDTH);
    localparam logic [16:0]       HALF_H_W   = 17'(SCREEN_HEIGHT / 2);
    localparam logic [16:0]       MAX_ROW_W  = 17'(SCREEN_HEIGHT - 1);
    localparam logic [7:0]        HALF_H_B   = 8'(SCREEN_HEIGHT / 2);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Bank 0 occupies entries 0..W-1 and bank 1 occupies W..2W-1.
    function automatic logic [ADDR_W-1:0] bank_addr(input logic bank, input logic [8:0] col);
        logic [ADDR_W-1:0] base;
        base = bank ? BANK1_BASE : {ADDR_W{1'b0}};
        return base + ADDR_W'(col);
    endfunction

    state_t                    state_r;
    state_t                    state_next_s;
    logic                      rd_bank_r;
    logic                      rd_bank_valid_r;
    logic [SCREEN_WIDTH-1:0]   written_map_r;
    logic [SCREEN_WIDTH-1:0]   written_map_next_s;
    logic [SCREEN_WIDTH-1:0]   wr_onehot_s;
    logic [CNT_W-1:0]          written_count_r;
    logic [CNT_W-1:0]          written_count_next_s;
    logic                      err_r;
    logic                      start_pending_r;
    logic                      frame_request_r;
    logic                      write_done_r;
    logic                      swap_s;

    logic                      wr_in_range_s;
    logic                      wr_new_s;
    logic [8:0]                wr_col_s;
    logic                      wr_bank_s;
    logic [ADDR_W-1:0]         wr_addr_s;
    logic [ENTRY_W-1:0]        wr_data_s;

    logic                      rd_in_range_s;
    logic [ADDR_W-1:0]         rd_addr_s;
    logic [ENTRY_W-1:0]        mem_r [DEPTH];
    logic [ENTRY_W-1:0]        rd_data_r;
    logic                      s1_valid_r;
    logic                      s1_oob_r;
    logic                      s1_empty_r;

    logic [16:0]               half_s;
    logic [16:0]               end_sum_s;
    logic [7:0]                draw_start_s;
    logic [7:0]                draw_end_s;

    logic [7:0]                draw_start_r;
    logic [7:0]                draw_end_r;
    logic                      wall_type_r;
    logic [3:0]                map_data_r;
    logic [15:0]               wall_x_r;
    logic                      rd_valid_r;

    // Write-side decode: range check, target bank and first-write detection.
    always_comb begin
        wr_in_range_s = valid_in && (hcount_ray_in < COL_LIMIT);
        wr_col_s      = wr_in_range_s ? hcount_ray_in : 9'd0;
        // During a swap the post-swap write bank is the current read bank.
        wr_bank_s     = swap_s ? rd_bank_r : ~rd_bank_r;
        wr_addr_s     = bank_addr(wr_bank_s, wr_col_s);
        wr_data_s     = {lineHeight_in, wallType_in, mapData_in, wallX_in};
        wr_new_s      = wr_in_range_s && (swap_s || !written_map_r[wr_col_s]);
        wr_onehot_s   = {{(SCREEN_WIDTH-1){1'b0}}, 1'b1} << wr_col_s;
    end

    // Bitmap and population count for the next cycle, restarting from empty on a swap.
    always_comb begin
        written_map_next_s = (swap_s ? {SCREEN_WIDTH{1'b0}} : written_map_r)
                           | (wr_in_range_s ? wr_onehot_s : {SCREEN_WIDTH{1'b0}});
        if (swap_s) begin
            written_count_next_s = wr_in_range_s ? CNT_ONE : {CNT_W{1'b0}};
        end else begin
            written_count_next_s = written_count_r + {{(CNT_W-1){1'b0}}, wr_new_s};
        end
    end

    // FSM state register.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = ST_FILL;
        case (state_r)
            ST_FILL: begin
                if (written_count_next_s == CNT_FULL) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_READY: begin
                if (frame_start_in) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_READY;
                end
            end
            default: state_next_s = ST_FILL;
        endcase
    end

    // FSM output decode: a frame start swaps banks only when the write bank is complete.
    always_comb begin
        swap_s = 1'b0;
        case (state_r)
            ST_FILL:  swap_s = 1'b0;
            ST_READY: swap_s = frame_start_in;
            default:  swap_s = 1'b0;
        endcase
    end

    // Bank control, fill tracking, status flags and frame requests.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_bank_r       <= 1'b0;
            rd_bank_valid_r <= 1'b0;
            written_map_r   <= {SCREEN_WIDTH{1'b0}};
            written_count_r <= {CNT_W{1'b0}};
            err_r           <= 1'b0;
            start_pending_r <= 1'b1;
            frame_request_r <= 1'b0;
            write_done_r    <= 1'b0;
        end else begin
            rd_bank_r       <= swap_s ? ~rd_bank_r : rd_bank_r;
            rd_bank_valid_r <= rd_bank_valid_r | swap_s;
            written_map_r   <= written_map_next_s;
            written_count_r <= written_count_next_s;
            err_r           <= err_r | (valid_in && !wr_in_range_s);
            start_pending_r <= 1'b0;
            frame_request_r <= start_pending_r | swap_s;
            write_done_r    <= (state_next_s == ST_READY);
        end
    end

    // Read address for the current read bank. Out-of-range columns are parked on entry 0.
    always_comb begin
        rd_in_range_s = rd_hcount_in < COL_LIMIT;
        rd_addr_s     = bank_addr(rd_bank_r, rd_in_range_s ? rd_hcount_in : 9'd0);
    end

    // Simple dual-port block RAM. A read colliding with a write returns the old data.
    always_ff @(posedge pixel_clk_in) begin
        if (valid_in && wr_in_range_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
        if (rd_req_in) begin
            rd_data_r <= mem_r[rd_addr_s];
        end
    end

    // Read stage 1: carry the request qualifiers alongside the RAM access.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid_r <= 1'b0;
            s1_oob_r   <= 1'b0;
            s1_empty_r <= 1'b0;
        end else begin
            s1_valid_r <= rd_req_in;
            s1_oob_r   <= !rd_in_range_s;
            s1_empty_r <= !rd_bank_valid_r;
        end
    end

    // Draw extents around the screen centre, clamped to the visible rows.
    always_comb begin
        half_s    = {1'b0, rd_data_r[36:21]} >> 1;
        end_sum_s = HALF_H_W + half_s;
        if (half_s >= HALF_H_W) begin
            draw_start_s = 8'd0;
        end else begin
            draw_start_s = 8'(HALF_H_W - half_s);
        end
        if (end_sum_s > MAX_ROW_W) begin
            draw_end_s = 8'(MAX_ROW_W);
        end else begin
            draw_end_s = 8'(end_sum_s);
        end
    end

    // Read stage 2: register the outputs, forcing a blank slice for an empty bank or a bad column.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            draw_start_r <= 8'd0;
            draw_end_r   <= 8'd0;
            wall_type_r  <= 1'b0;
            map_data_r   <= 4'd0;
            wall_x_r     <= 16'd0;
            rd_valid_r   <= 1'b0;
        end else begin
            rd_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                if (s1_empty_r || s1_oob_r) begin
                    draw_start_r <= HALF_H_B;
                    draw_end_r   <= HALF_H_B;
                    wall_type_r  <= 1'b0;
                    map_data_r   <= 4'd0;
                    wall_x_r     <= 16'd0;
                end else begin
                    draw_start_r <= draw_start_s;
                    draw_end_r   <= draw_end_s;
                    wall_type_r  <= rd_data_r[20];
                    map_data_r   <= rd_data_r[19:16];
                    wall_x_r     <= rd_data_r[15:0];
                end
            end
        end
    end

    assign drawStart_out     = draw_start_r;
    assign drawEnd_out       = draw_end_r;
    assign wallType_out      = wall_type_r;
    assign mapData_out       = map_data_r;
    assign wallX_out         = wall_x_r;
    assign rd_valid_out      = rd_valid_r;
    assign frame_request_out = frame_request_r;
    assign write_done_out    = write_done_r;
    assign err_out           = err_r;

endmodule
